// File: rtl/dev_uart_rx.sv
// dev_uart_rx -- 8N1 UART receiver with a one-byte output buffer.
//
// The receiver samples a serial line that has already been synchronized and
// de-glitched upstream. A frame starts on the upstream falling-edge pulse.
// Each bit is then sampled once, near its centre, using a single down-counter.
//
// Ports
//   clk         sole clock, rising edge
//   rst         asynchronous reset, active low
//   rx          serial line level, idle high
//   rx_fall     one-cycle pulse marking a 1->0 transition of rx
//   data[7:0]   last received byte (LSB received first)
//   data_valid  data holds an unconsumed byte
//   data_ready  consumer takes data when data_valid && data_ready
//   frame_err   one-cycle pulse: stop bit sampled low, byte discarded
//   overrun     sticky: a finished byte was dropped because data was still full
//   ovr_clr     synchronous clear of overrun (a coincident new overrun wins)
//   busy        receiver is inside a frame
//
// CLKS_PER_BIT must be even and >= 4.
module dev_uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_fall,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       ovr_clr,
  output logic       busy
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  // The first reload is half a bit, so that every later sample lands mid-bit.
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        st;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;

  logic smp;       // sample event for the current bit
  logic stop_ok;   // good stop bit: a byte is ready to commit
  logic stop_bad;  // stop bit low: framing error
  logic consume;

  assign smp      = (st != IDLE) && (cnt == '0);
  assign stop_ok  = smp && (st == STOP) && rx;
  assign stop_bad = smp && (st == STOP) && !rx;
  assign consume  = data_valid && data_ready;
  assign busy     = (st != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st         <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      sh         <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // ---- frame sequencing ----
      case (st)
        IDLE: begin
          // rx_fall is only looked at here, so pulses inside a frame are ignored.
          if (rx_fall) begin
            st  <= START;
            cnt <= HALF;
          end
        end
        default: begin
          cnt <= smp ? FULL : cnt - 1'b1;
          if (smp) begin
            case (st)
              START: begin
                // Line back high at mid start bit: it was noise.
                // Drop it silently.
                if (rx) st <= IDLE;
                else begin
                  st  <= DATA;
                  idx <= '0;
                end
              end
              DATA: begin
                sh[idx] <= rx;
                idx     <= idx + 1'b1;
                if (idx == 3'd7) st <= STOP;
              end
              default: st <= IDLE;  // STOP: ready for a new start next cycle
            endcase
          end
        end
      endcase

      // ---- output buffer ----
      frame_err <= stop_bad;

      // A consume in the commit cycle frees the slot, so the new byte lands
      // and data_valid simply stays up.
      if (stop_ok && (!data_valid || consume)) begin
        data       <= sh;
        data_valid <= 1'b1;
      end else if (consume) begin
        data_valid <= 1'b0;
      end

      if (stop_ok && data_valid && !consume) overrun <= 1'b1;
      else if (ovr_clr)                      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dev_uart_rx.sv
// Bench for dev_uart_rx (CLKS_PER_BIT = 16).
// Each frame is driven as ten 16-cycle bit slots.
// The reference model only needs to know when a frame's stop bit is sampled.
// That point comes from arithmetic: for rx_fall sampled at edge s, the outcome
// is registered at edge s + 8 + 9*16 = s + 152.
// At that edge the model applies the buffer rules (commit / drop+overrun /
// frame error). Between frames it applies the consume / clear rules.
module tb_dev_uart_rx;

  localparam int CPB = 16;
  localparam int OUTCOME = CPB / 2 + 9 * CPB;  // 152 edges after the start edge

  logic       clk = 1'b0;
  logic       rst, rx, rx_fall, data_ready, ovr_clr;
  logic [7:0] data;
  logic       data_valid, frame_err, overrun, busy;

  dev_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_fall(rx_fall),
    .data(data), .data_valid(data_valid), .data_ready(data_ready),
    .frame_err(frame_err), .overrun(overrun), .ovr_clr(ovr_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         e;
    logic       ok;
    logic [7:0] b;
  } ev_t;

  ev_t        q[$];
  int         edge_n = 0;
  int         n_cmp  = 0;
  int         n_bad  = 0;
  logic [7:0] m_data;
  logic       m_valid, m_ovr, m_ferr;
  int         m_bs, m_bu;  // busy for edges in [m_bs, m_bu)
  bit         rand_hs = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    m_data = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    m_bs = 0; m_bu = 0;
    q.delete();
  endtask

  task automatic check_all();
    logic mb;
    mb = (edge_n >= m_bs) && (edge_n < m_bu);
    chk("data",       data,               m_data);
    chk("data_valid", 8'(data_valid),     8'(m_valid));
    chk("overrun",    8'(overrun),        8'(m_ovr));
    chk("frame_err",  8'(frame_err),      8'(m_ferr));
    chk("busy",       8'(busy),           8'(mb));
  endtask

  // One clock: let the edge happen, advance the model, check outputs #1 later.
  task automatic tick();
    ev_t  ev;
    logic cons, commit, set_o;
    @(posedge clk);
    edge_n++;
    commit = 1'b0; set_o = 1'b0; m_ferr = 1'b0;
    if (!rst) model_reset();
    else begin
      cons = m_valid && data_ready;
      if (q.size() != 0 && q[0].e == edge_n) begin
        ev = q.pop_front();
        if (ev.ok) commit = 1'b1; else m_ferr = 1'b1;
      end
      if (commit && (!m_valid || cons)) begin
        m_data = ev.b; m_valid = 1'b1;
      end else if (commit) set_o = 1'b1;
      else if (cons) m_valid = 1'b0;
      if (set_o) m_ovr = 1'b1;
      else if (ovr_clr) m_ovr = 1'b0;
    end
    #1;
    check_all();
  endtask

  task automatic rand_hs_drive();
    data_ready = ($urandom_range(0, 3) == 0);
    ovr_clr    = ($urandom_range(0, 15) == 0);
  endtask

  task automatic idle(input int n);
    rx = 1'b1; rx_fall = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (rand_hs) rand_hs_drive();
      tick();
    end
    data_ready = 1'b0; ovr_clr = 1'b0;
  endtask

  // Drive one frame. Cycle k of the frame is sampled at edge s+k.
  // stop_len < 16 shortens the stop bit so the next frame can start right
  // after the stop sample. The *_at arguments (-1 = unused) pulse the named
  // input during cycle k. abort_at pulls reset in the middle of cycle k.
  task automatic frame(input logic [7:0] b, input logic stopb, input int stop_len,
                       input int abort_at, input int rdy_at, input int clr_at,
                       input int glitch_at);
    logic [9:0] bits;
    int         s;
    bits = {stopb, b, 1'b0};
    s    = edge_n + 1;
    q.push_back('{e: s + OUTCOME, ok: stopb, b: b});
    m_bs = s; m_bu = s + OUTCOME;
    for (int k = 0; k < 9 * CPB + stop_len; k++) begin
      rx      = bits[k / CPB];
      rx_fall = (k == 0) || (k == glitch_at);
      if (rand_hs) rand_hs_drive();
      else begin
        data_ready = (k == rdy_at);
        ovr_clr    = (k == clr_at);
      end
      if (k == abort_at) begin
        #1 rst = 1'b0;
        #1;
        model_reset();
        chk("rst_data",       data,           8'h00);
        chk("rst_data_valid", 8'(data_valid), 8'h00);
        chk("rst_overrun",    8'(overrun),    8'h00);
        chk("rst_frame_err",  8'(frame_err),  8'h00);
        chk("rst_busy",       8'(busy),       8'h00);
        rx = 1'b1; rx_fall = 1'b0; data_ready = 1'b0; ovr_clr = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        return;
      end
      tick();
    end
    rx = 1'b1; rx_fall = 1'b0; data_ready = 1'b0; ovr_clr = 1'b0;
  endtask

  // Start bit that ends before its mid-point: noise, no frame.
  task automatic false_start(input int low_len);
    int s;
    s = edge_n + 1;
    m_bs = s; m_bu = s + CPB / 2;
    for (int k = 0; k < 20; k++) begin
      rx      = (k >= low_len);
      rx_fall = (k == 0);
      if (rand_hs) rand_hs_drive();
      tick();
    end
    rx_fall = 1'b0; data_ready = 1'b0; ovr_clr = 1'b0;
  endtask

  task automatic drain();
    data_ready = 1'b1; tick(); data_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; rx = 1'b1; rx_fall = 1'b0; data_ready = 1'b0; ovr_clr = 1'b0;
    model_reset();
    #2;
    chk("reset_data",  data,           8'h00);
    chk("reset_valid", 8'(data_valid), 8'h00);
    chk("reset_busy",  8'(busy),       8'h00);
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    idle(4);

    // Clean 0xA5 frame, nobody consuming.
    frame(8'hA5, 1'b1, 16, -1, -1, -1, -1);
    chk("a5_data",  data,           8'hA5);
    chk("a5_valid", 8'(data_valid), 8'h01);
    idle(3);

    // Four-cycle start glitch.
    false_start(4);
    chk("false_busy",  8'(busy),       8'h00);
    chk("false_data",  data,           8'hA5);

    // Bad stop bit with an empty buffer.
    drain();
    frame(8'h3C, 1'b0, 16, -1, -1, -1, -1);
    chk("ferr_valid", 8'(data_valid), 8'h00);
    chk("ferr_data",  data,           8'hA5);

    // Back-to-back 0x11, 0x22 with no consumer -> overrun, then clear.
    frame(8'h11, 1'b1, 9, -1, -1, -1, -1);
    frame(8'h22, 1'b1, 16, -1, -1, -1, -1);
    chk("ovr_data", data,         8'h11);
    chk("ovr_flag", 8'(overrun),  8'h01);
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    chk("ovr_cleared", 8'(overrun), 8'h00);

    // Clear and a new overrun on the same edge: set wins.
    frame(8'h77, 1'b1, 16, -1, -1, 152, -1);
    chk("setwins_ovr",  8'(overrun), 8'h01);
    chk("setwins_data", data,        8'h11);
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;

    // Consume exactly in the commit cycle of the second frame.
    drain();
    idle(5);  // data_ready idle with empty buffer has no effect
    data_ready = 1'b1; tick(); tick(); data_ready = 1'b0;
    frame(8'h11, 1'b1, 16, -1, -1, -1, -1);
    frame(8'h22, 1'b1, 16, -1, 152, -1, 60);
    chk("samecyc_data",  data,           8'h22);
    chk("samecyc_valid", 8'(data_valid), 8'h01);
    chk("samecyc_ovr",   8'(overrun),    8'h00);

    // Fill and overrun, then reset mid-frame, then a clean frame.
    frame(8'h33, 1'b1, 16, -1, -1, -1, -1);
    frame(8'hA5, 1'b1, 16, 80, -1, -1, -1);
    idle(4);
    frame(8'h5A, 1'b1, 16, -1, -1, -1, -1);
    chk("post_rst_data",  data,           8'h5A);
    chk("post_rst_valid", 8'(data_valid), 8'h01);

    // Randomized traffic and handshakes.
    rand_hs = 1'b1;
    for (int f = 0; f < 12; f++) begin
      logic [7:0] b;
      logic       sb;
      b  = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 5) == 0) false_start(int'($urandom_range(1, 6)));
      frame(b, sb, (sb && $urandom_range(0, 1) == 1) ? 9 : 16, -1, -1, -1,
            ($urandom_range(0, 1) == 1) ? int'($urandom_range(20, 130)) : -1);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 20)));
    end
    rand_hs = 1'b0;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dev_uart_rx.md
DEV_UART_RX -- requirements
Module: dev_uart_rx

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 16, clock cycles per serial bit; SHALL be even and >= 4.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  asynchronous, active-low reset; asserted (0) forces reset state immediately, independent of clk.
REQ-004 rx  input  1  synchronized serial line level from the upstream dev_filter b output; idle high.
REQ-005 rx_fall  input  1  one-cycle pulse from the upstream dev_filter fall output, marking a 1->0 transition of rx.
REQ-006 data  output  8  last received byte, LSB received first.
REQ-007 data_valid  output  1  high while data holds an unconsumed byte.
REQ-008 data_ready  input  1  consumer accepts data in any cycle where data_valid && data_ready.
REQ-009 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 overrun  output  1  sticky: a completed byte was dropped because the buffer was full.
REQ-011 ovr_clr  input  1  synchronous clear of overrun.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP; single down-counter cnt of width clog2(CLKS_PER_BIT), plus a 3-bit bit index and an 8-bit shift register.
REQ-014 IDLE: on rx_fall=1 -> START, cnt <= CLKS_PER_BIT/2-1; rx_fall SHALL be ignored in every other state.
REQ-015 Each non-IDLE state decrements cnt every cycle; the sample event is the cycle with cnt==0, at which cnt reloads CLKS_PER_BIT-1.
REQ-016 START sample: rx=0 -> DATA, bit index 0; rx=1 -> IDLE (false start, no flag, no output change).
REQ-017 DATA sample: rx shifted into bit[index] (LSB first); after index 7 -> STOP.
REQ-018 STOP sample: rx=1 -> byte committed (REQ-019); rx=0 -> frame_err=1 for exactly the next cycle, byte discarded; either way -> IDLE in the same cycle.
REQ-019 Commit: data and data_valid update the cycle after the STOP sample; with rx_fall at cycle T, data_valid rises at T + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1.
REQ-020 data_valid SHALL stay high and data stable until a cycle with data_ready=1; data_valid then clears the next cycle unless REQ-021 applies.
REQ-021 Commit in the same cycle as a consume: new byte loaded, data_valid stays 1, overrun unchanged.
REQ-022 Commit while data_valid=1 and no consume: new byte dropped, data unchanged, overrun <= 1.
REQ-023 ovr_clr=1 clears overrun; if it coincides with a new overrun event, overrun SHALL end at 1 (set wins).
REQ-024 data_ready while data_valid=0 SHALL have no effect.
REQ-025 A frame whose STOP sample has occurred SHALL accept a new rx_fall from the next cycle (back-to-back frames, no idle gap needed).

Reset
REQ-026 On rst=0: state IDLE, cnt=0, index=0, shift register=0, data=8'h00, data_valid=0, frame_err=0, overrun=0, busy=0.
REQ-027 Reset mid-frame SHALL abandon the frame with no commit, frame_err or overrun; after release, the first rx_fall starts a fresh frame.

Verification (CLKS_PER_BIT=16, rx_fall at cycle T)
REQ-028 Frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1), data_ready=0 -> data_valid rises at T+153, data=8'hA5, frame_err never 1.
REQ-029 rx low for 4 cycles only, then high -> returns to IDLE at T+8, busy low, data_valid/frame_err stay 0.
REQ-030 Frame 0x3C with stop bit held 0 -> frame_err=1 for exactly cycle T+153, data_valid stays 0, data unchanged.
REQ-031 Frames 0x11 then 0x22 back to back, data_ready=0 -> data=8'h11, data_valid=1, overrun=1 after the second frame; ovr_clr pulse -> overrun=0.
REQ-032 Second frame 0x22 with data_ready=1 exactly in its commit cycle -> data=8'h22, data_valid stays 1, overrun=0.
REQ-033 rst=0 at T+80 mid 0xA5 frame -> all outputs zero immediately; after release, a clean 0x5A frame -> data=8'h5A.
